fwd_pipe: RTL and testbench

FWD_PIPE -- requirements
Module: fwd_pipe

---
 rtl/fwd_pipe.sv | 132 +++++++++++++
 tb/tb_fwd_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_pipe.sv
// In-order instruction pipe with load-use hazard stall and global backpressure.
// Optional FWD_PIPE_STATS_EN adds 32-bit issue/stall/backpressure counters.
`timescale 1ns/1ps
module fwd_pipe #(
    parameter int          DEPTH    = 2,
    parameter int          XLEN     = 32,
    parameter int          RW       = 5,
    // Encoding of the memory instruction type; must match `MEM in const.v.
    parameter logic [2:0]  MEM_TYPE = 3'd2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            in_valid,
    input  logic            in_is_vec,
    input  logic [2:0]      in_type,
    input  logic [RW-1:0]   in_rd,
    input  logic [RW-1:0]   in_rs1,
    input  logic [RW-1:0]   in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    output logic            in_ready,
    output logic            stall,
    input  logic            out_ready,
    output logic            out_valid,
    output logic            out_is_vec,
    output logic [2:0]      out_type,
    output logic [RW-1:0]   out_rd,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm
`ifdef FWD_PIPE_STATS_EN
    ,
    output logic [31:0]     stat_issue,
    output logic [31:0]     stat_stall,
    output logic [31:0]     stat_bp
`endif
);

    typedef struct packed {
        logic            valid;
        logic            is_vec;
        logic [2:0]      typ;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
    } stage_t;

    stage_t stage_q [DEPTH];
    stage_t stage_d [DEPTH];

    logic adv;
    logic hazard;
    logic hit;
    logic accept;

    assign adv = rdy && !(out_valid && !out_ready);

    // The last stage is scanned too, even while it is leaving this cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns every variable (no latches).
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (stage_q[k].valid && stage_q[k].typ == MEM_TYPE &&
                stage_q[k].rd != '0 && stage_q[k].is_vec == in_is_vec &&
                (stage_q[k].rd == in_rs1 || stage_q[k].rd == in_rs2)) begin
                hit = 1'b1;
            end
        end
    end

    assign hazard   = in_valid && hit;
    assign stall    = hazard;
    assign in_ready = adv && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        stage_d = stage_q;
        if (adv) begin
            // A bubble still carries the input fields; only valid matters.
            stage_d[0].valid  = accept;
            stage_d[0].is_vec = in_is_vec;
            stage_d[0].typ    = in_type;
            stage_d[0].rd     = in_rd;
            stage_d[0].pc     = in_pc;
            stage_d[0].imm    = in_imm;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every field is cleared, not just valid, so out_* read as zero after reset.
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_valid  = stage_q[DEPTH-1].valid;
    assign out_is_vec = stage_q[DEPTH-1].is_vec;
    assign out_type   = stage_q[DEPTH-1].typ;
    assign out_rd     = stage_q[DEPTH-1].rd;
    assign out_pc     = stage_q[DEPTH-1].pc;
    assign out_imm    = stage_q[DEPTH-1].imm;

`ifdef FWD_PIPE_STATS_EN
    logic [31:0] stat_issue_q;
    logic [31:0] stat_stall_q;
    logic [31:0] stat_bp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issue_q <= '0;
            stat_stall_q <= '0;
            stat_bp_q    <= '0;
        end else begin
            if (accept)                          stat_issue_q <= stat_issue_q + 32'd1;
            if (rdy && hazard)                   stat_stall_q <= stat_stall_q + 32'd1;
            if (rdy && out_valid && !out_ready)  stat_bp_q    <= stat_bp_q + 32'd1;
        end
    end

    assign stat_issue = stat_issue_q;
    assign stat_stall = stat_stall_q;
    assign stat_bp    = stat_bp_q;
`endif

endmodule

// File: tb/tb_fwd_pipe.sv
// Scoreboard bench for fwd_pipe (DEPTH=2): directed scenarios push expected
// instructions; a negedge monitor pops and compares every output transfer.
`timescale 1ns/1ps
module tb_fwd_pipe;

    localparam int         XLEN  = 32;
    localparam int         RW    = 5;
    localparam logic [2:0] T_ALU = 3'd0;
    localparam logic [2:0] T_MEM = 3'd2;

    typedef struct packed {
        logic            is_vec;
        logic [2:0]      typ;
        logic [RW-1:0]   rd;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
    } instr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rdy = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_is_vec = 1'b0;
    logic [2:0]      in_type = '0;
    logic [RW-1:0]   in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [XLEN-1:0] in_pc = '0, in_imm = '0;
    logic            in_ready, stall;
    logic            out_ready = 1'b1;
    logic            out_valid, out_is_vec;
    logic [2:0]      out_type;
    logic [RW-1:0]   out_rd;
    logic [XLEN-1:0] out_pc, out_imm;
`ifdef FWD_PIPE_STATS_EN
    logic [31:0]     stat_issue, stat_stall, stat_bp;
`endif

    instr_t exp_q [$];
    int     xfer_cyc [$];
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;

    fwd_pipe #(.DEPTH(2), .XLEN(XLEN), .RW(RW), .MEM_TYPE(T_MEM)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_is_vec(in_is_vec), .in_type(in_type),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_ready(in_ready), .stall(stall), .out_ready(out_ready),
        .out_valid(out_valid), .out_is_vec(out_is_vec), .out_type(out_type),
        .out_rd(out_rd), .out_pc(out_pc), .out_imm(out_imm)
`ifdef FWD_PIPE_STATS_EN
        ,
        .stat_issue(stat_issue), .stat_stall(stat_stall), .stat_bp(stat_bp)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic instr_t mk(input logic v, input logic [2:0] t, input logic [RW-1:0] rd,
                                  input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                                  input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
        instr_t i;
        i.is_vec = v; i.typ = t; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.pc = pc; i.imm = imm;
        return i;
    endfunction

    // Monitor: every transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        instr_t e;
        if (!rst && rdy && out_valid && out_ready) begin
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got pc 0x%0h expected no transfer (cycle %0d)", out_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_rd", out_rd, e.rd);
                check("out_imm", out_imm, e.imm);
                check("out_type", out_type, e.typ);
                check("out_is_vec", out_is_vec, e.is_vec);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic present(input instr_t i, input logic exp_rdy, input logic exp_stall, input string tag);
        in_valid = 1'b1;
        in_is_vec = i.is_vec; in_type = i.typ; in_rd = i.rd;
        in_rs1 = i.rs1; in_rs2 = i.rs2; in_pc = i.pc; in_imm = i.imm;
        #1;
        check({tag, "_in_ready"}, in_ready, exp_rdy);
        check({tag, "_stall"}, stall, exp_stall);
        if (exp_rdy) exp_q.push_back(i);
    endtask

    task automatic drain(input int n, input string tag);
        in_valid = 1'b0;
        repeat (n) tick();
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        instr_t a, b, c, m, u, m0, s1, mv, s2, v;
        int n0;

        // Scenario 1: reset values, then single ALU instruction latency.
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_is_vec", out_is_vec, 0);
        check("rst_out_type", out_type, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_imm", out_imm, 0);
        a = mk(0, T_ALU, 5'd3, 5'd1, 5'd2, 32'h100, 32'h11);
        present(a, 1, 0, "s1_issue");
        tick();
        in_valid = 1'b0;
        #1;
        check("s1_lat1_valid", out_valid, 0);
        tick();
        check("s1_lat2_valid", out_valid, 1);
        check("s1_lat2_rd", out_rd, 3);
        check("s1_lat2_pc", out_pc, 32'h100);
        drain(3, "s1");

        // Scenario 2: load-use hazard stalls for two cycles, two bubbles result.
        do_reset();
        n0 = xfer_cyc.size();
        m = mk(0, T_MEM, 5'd5, 5'd0, 5'd0, 32'h200, 32'h20);
        u = mk(0, T_ALU, 5'd6, 5'd5, 5'd7, 32'h204, 32'h24);
        present(m, 1, 0, "s2_mem");
        tick();
        present(u, 0, 1, "s2_c1");
        tick();
        present(u, 0, 1, "s2_c2");
        tick();
        present(u, 1, 0, "s2_c3");
        tick();
        drain(4, "s2");
        if (xfer_cyc.size() >= n0 + 2) begin
            check("s2_bubbles", xfer_cyc[n0+1] - xfer_cyc[n0] - 1, 2);
        end else begin
            checks++;
            failures++;
            $display("FAIL s2_bubbles: got %0d transfers expected 2", xfer_cyc.size() - n0);
        end
`ifdef FWD_PIPE_STATS_EN
        check("s2_stat_issue", stat_issue, 2);
        check("s2_stat_stall", stat_stall, 2);
        check("s2_stat_bp", stat_bp, 0);
`endif

        // Scenario 3: rd=0 and namespace mismatch never stall; matching vector does.
        do_reset();
        m0 = mk(0, T_MEM, 5'd0, 5'd0, 5'd0, 32'h300, 32'h30);
        s1 = mk(0, T_ALU, 5'd1, 5'd2, 5'd0, 32'h304, 32'h31);
        mv = mk(1, T_MEM, 5'd4, 5'd0, 5'd0, 32'h308, 32'h32);
        s2 = mk(0, T_ALU, 5'd2, 5'd3, 5'd4, 32'h30c, 32'h33);
        v  = mk(1, T_ALU, 5'd6, 5'd4, 5'd1, 32'h310, 32'h34);
        present(m0, 1, 0, "s3_mem_rd0");
        tick();
        present(s1, 1, 0, "s3_rs2_zero");
        tick();
        present(mv, 1, 0, "s3_vec_mem");
        tick();
        present(s2, 1, 0, "s3_scalar_vs_vec");
        tick();
        present(v, 0, 1, "s3_vec_last_stage");
        tick();
        present(v, 1, 0, "s3_vec_accept");
        tick();
        drain(4, "s3");

        // Scenario 4: backpressure freezes the pipe for three cycles.
        do_reset();
        a = mk(0, T_ALU, 5'd7, 5'd0, 5'd0, 32'h400, 32'h40);
        b = mk(1, T_ALU, 5'd8, 5'd0, 5'd0, 32'h404, 32'h44);
        c = mk(0, T_MEM, 5'd9, 5'd0, 5'd0, 32'h408, 32'h48);
        present(a, 1, 0, "s4_a");
        tick();
        present(b, 1, 0, "s4_b");
        tick();
        for (int j = 0; j < 3; j++) begin
            out_ready = 1'b0;
            present(c, 0, 0, "s4_bp");
            check("s4_bp_out_valid", out_valid, 1);
            check("s4_bp_out_pc", out_pc, 32'h400);
            check("s4_bp_out_rd", out_rd, 7);
            tick();
        end
        out_ready = 1'b1;
        present(c, 1, 0, "s4_release");
        tick();
        drain(4, "s4");
`ifdef FWD_PIPE_STATS_EN
        check("s4_stat_issue", stat_issue, 3);
        check("s4_stat_stall", stat_stall, 0);
        check("s4_stat_bp", stat_bp, 3);
`endif

        // Scenario 5: rdy low freezes state; reset then discards in-flight work.
        do_reset();
        a = mk(0, T_ALU, 5'd10, 5'd0, 5'd0, 32'h500, 32'h50);
        b = mk(0, T_MEM, 5'd9, 5'd0, 5'd0, 32'h504, 32'h54);
        c = mk(0, T_ALU, 5'd11, 5'd9, 5'd0, 32'h508, 32'h58);
        present(a, 1, 0, "s5_a");
        tick();
        present(b, 1, 0, "s5_b");
        tick();
        for (int j = 0; j < 2; j++) begin
            rdy = 1'b0;
            present(c, 0, 1, "s5_rdy_low");
            check("s5_hold_valid", out_valid, 1);
            check("s5_hold_pc", out_pc, 32'h500);
            tick();
        end
        do_reset();
        rdy = 1'b1;
        #1;
        check("s5_post_rst_valid", out_valid, 0);
        check("s5_post_rst_pc", out_pc, 0);
`ifdef FWD_PIPE_STATS_EN
        check("s5_stat_issue_rst", stat_issue, 0);
`endif
        present(c, 1, 0, "s5_post_rst");
        tick();
        in_valid = 1'b0;
        #1;
        check("s5_no_leak_valid", out_valid, 0);
        drain(4, "s5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
